// File: rtl/vga_stream_source.sv
// vga_stream_source
//
// Raster source for the convolution filter bank. Walks the 800x525 VGA
// timing (640x480 visible), fetches each pixel from a 320x240 RGB565 frame
// buffer with 2x nearest-neighbour upscale, converts it to 8-bit luma, and
// presents pixel coordinates, display enable, luma and the active-low syncs
// all aligned to the same output pixel.
//
// Pipeline (each stage advances on a pclk_en tick):
//   stage 0 : h/v counters, frame-buffer read issued for active pixels
//   stage 1 : counter copy; read data captured one clk after rd_en
//   stage 2 : luma conversion and registered outputs
//
// Ports:
//   clk          system clock
//   rst_n        asynchronous reset, active-low
//   pclk_en      pixel-tick enable; timing advances only when high
//   rd_en        frame-buffer read strobe, one clk wide
//   rd_addr      frame-buffer word address (holds between reads)
//   rd_data      RGB565 word, valid exactly 1 clk after rd_en
//   x_pixel      column of current output pixel (full raster count)
//   y_pixel      row of current output pixel (full raster count)
//   disp_enable  high when the output pixel is in the active area
//   gray_in_out  luma of the current output pixel, 0 outside active area
//   h_sync       active-low horizontal sync
//   v_sync       active-low vertical sync
//   frame_start  one-clk pulse with the first active output pixel of a frame

module vga_stream_source #(
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned H_FP     = 16,
  parameter int unsigned H_SYNC   = 96,
  parameter int unsigned H_BP     = 48,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned V_FP     = 10,
  parameter int unsigned V_SYNC   = 2,
  parameter int unsigned V_BP     = 33,
  parameter int unsigned ADDR_W   = 17
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              pclk_en,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [15:0]       rd_data,
  output logic [9:0]        x_pixel,
  output logic [9:0]        y_pixel,
  output logic              disp_enable,
  output logic [7:0]        gray_in_out,
  output logic              h_sync,
  output logic              v_sync,
  output logic              frame_start
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [9:0] H_ACT    = 10'(H_ACTIVE);
  localparam logic [9:0] V_ACT    = 10'(V_ACTIVE);
  localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0] HS_FIRST = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HS_LAST  = 10'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [9:0] VS_FIRST = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VS_LAST  = 10'(V_ACTIVE + V_FP + V_SYNC - 1);

  // ---------------------------------------------------------------------------
  // Stage 0: raster counters
  // ---------------------------------------------------------------------------
  logic [9:0] h_cnt_q;
  logic [9:0] v_cnt_q;
  logic       active_s0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h_cnt_q <= '0;
      v_cnt_q <= '0;
    end else if (pclk_en) begin
      if (h_cnt_q == H_LAST) begin
        h_cnt_q <= '0;
        v_cnt_q <= (v_cnt_q == V_LAST) ? '0 : v_cnt_q + 10'd1;
      end else begin
        h_cnt_q <= h_cnt_q + 10'd1;
      end
    end
  end

  assign active_s0 = (h_cnt_q < H_ACT) && (v_cnt_q < V_ACT);

  // ---------------------------------------------------------------------------
  // Stage 0: frame-buffer read issue
  // ---------------------------------------------------------------------------
  // The buffer is 320 words wide; halving both counts gives the 2x upscale.
  // 320 = 256 + 64, so the row base is built from two shifts.
  logic [ADDR_W-1:0] src_x;
  logic [ADDR_W-1:0] src_y;
  logic [ADDR_W-1:0] addr_calc;
  logic [ADDR_W-1:0] addr_q;
  logic              rd_pend_q;

  assign src_x     = ADDR_W'(h_cnt_q[9:1]);
  assign src_y     = ADDR_W'(v_cnt_q[9:1]);
  assign addr_calc = (src_y << 8) + (src_y << 6) + src_x;

  // The strobe is issued during the tick clk itself so the RAM's one-clk
  // read latency lands the data in time for the next tick at full rate.
  // rst_n gates it so no read escapes while the design is held in reset.
  assign rd_en   = rst_n & pclk_en & active_s0;
  assign rd_addr = rd_en ? addr_calc : addr_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q    <= '0;
      rd_pend_q <= 1'b0;
    end else begin
      addr_q    <= rd_addr;
      rd_pend_q <= rd_en;
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 1: counter copy and read-data capture
  // ---------------------------------------------------------------------------
  logic [9:0]  s1_h_q;
  logic [9:0]  s1_v_q;
  logic        s1_act_q;
  logic        s1_vld_q;
  logic [15:0] data_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_h_q   <= '0;
      s1_v_q   <= '0;
      s1_act_q <= 1'b0;
      s1_vld_q <= 1'b0;
    end else if (pclk_en) begin
      s1_h_q   <= h_cnt_q;
      s1_v_q   <= v_cnt_q;
      s1_act_q <= active_s0;
      s1_vld_q <= 1'b1;
    end
  end

  // Capture happens on the clk after rd_en regardless of pclk_en, so a slow
  // pixel tick still finds the word parked here.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q <= '0;
    end else if (rd_pend_q) begin
      data_q <= rd_data;
    end else if (pclk_en && !active_s0) begin
      data_q <= '0;
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 2: luma conversion
  // ---------------------------------------------------------------------------
  // At full rate the stage-2 tick coincides with the capture clk, so the RAM
  // word is taken straight from rd_data; otherwise it has already landed in
  // data_q.
  logic [15:0] pix;
  logic [7:0]  r8;
  logic [7:0]  g8;
  logic [7:0]  b8;
  logic [15:0] luma;
  logic [7:0]  gray_s2;
  logic        hs_s2;
  logic        vs_s2;
  logic        first_s2;

  always_comb begin
    pix   = rd_pend_q ? rd_data : data_q;
    r8    = {pix[15:11], pix[15:13]};
    g8    = {pix[10:5],  pix[10:9]};
    b8    = {pix[4:0],   pix[4:2]};
    // Weights sum to 256, so the 16-bit sum tops out at 255 * 256.
    luma  = (16'd77 * {8'd0, r8}) + (16'd150 * {8'd0, g8}) + (16'd29 * {8'd0, b8});
    gray_s2  = s1_act_q ? luma[15:8] : 8'd0;
    hs_s2    = !((s1_h_q >= HS_FIRST) && (s1_h_q <= HS_LAST));
    vs_s2    = !((s1_v_q >= VS_FIRST) && (s1_v_q <= VS_LAST));
    // s1_vld_q stops the cleared pipeline from faking a frame start.
    first_s2 = s1_vld_q && (s1_h_q == '0) && (s1_v_q == '0);
  end

  // ---------------------------------------------------------------------------
  // Stage 2: registered outputs
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_pixel     <= '0;
      y_pixel     <= '0;
      disp_enable <= 1'b0;
      gray_in_out <= '0;
      h_sync      <= 1'b1;
      v_sync      <= 1'b1;
      frame_start <= 1'b0;
    end else begin
      frame_start <= 1'b0;
      if (pclk_en) begin
        x_pixel     <= s1_h_q;
        y_pixel     <= s1_v_q;
        disp_enable <= s1_act_q;
        gray_in_out <= gray_s2;
        h_sync      <= hs_s2;
        v_sync      <= vs_s2;
        frame_start <= first_s2;
      end
    end
  end

endmodule

// File: tb/tb_vga_stream_source.sv
// Bench for vga_stream_source. Uses full-size horizontal timing and a short
// vertical raster (8 visible lines, 14 total) so whole frames fit in a short
// run. A RAM model with a one-clk read latency serves the frame buffer; a
// raster model pushes the expected output pixel on every tick and pops it
// when the DUT presents it two ticks later.

module tb_vga_stream_source;

  localparam int HA = 640, HF = 16, HS = 96, HB = 48;
  localparam int VA = 8, VF = 2, VS = 2, VB = 2;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;

  typedef struct packed {
    logic [9:0] x;
    logic [9:0] y;
    logic       de;
    logic [7:0] g;
    logic       hs;
    logic       vs;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        pclk_en = 1'b0;
  logic        rd_en;
  logic [16:0] rd_addr;
  logic [15:0] rd_data = '0;
  logic [9:0]  x_pixel;
  logic [9:0]  y_pixel;
  logic        disp_enable;
  logic [7:0]  gray;
  logic        h_sync;
  logic        v_sync;
  logic        frame_start;

  logic [15:0] mem [0:76799];

  exp_t q[$];
  exp_t last;
  logic have_last;
  int   mh, mv;
  int   n_vec, n_err;
  int   cyc, fs_cnt, hs_low_cnt, vs_low_cnt, last_fall, hs_period;
  logic prev_hs;

  vga_stream_source #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .ADDR_W(17)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .pclk_en    (pclk_en),
    .rd_en      (rd_en),
    .rd_addr    (rd_addr),
    .rd_data    (rd_data),
    .x_pixel    (x_pixel),
    .y_pixel    (y_pixel),
    .disp_enable(disp_enable),
    .gray_in_out(gray),
    .h_sync     (h_sync),
    .v_sync     (v_sync),
    .frame_start(frame_start)
  );

  always #5 clk = ~clk;

  // Synchronous RAM: data valid the clk after the strobe is sampled.
  always @(posedge clk) begin
    if (rd_en) rd_data <= mem[rd_addr];
  end

  function automatic logic [7:0] luma(input logic [15:0] p);
    int r5, g6, b5, r, g, b;
    r5 = int'(p[15:11]);
    g6 = int'(p[10:5]);
    b5 = int'(p[4:0]);
    r  = r5 * 8 + r5 / 4;
    g  = g6 * 4 + g6 / 16;
    b  = b5 * 8 + b5 / 4;
    return 8'((77 * r + 150 * g + 29 * b) / 256);
  endfunction

  function automatic exp_t model(input int h, input int v);
    exp_t e;
    e.x  = 10'(h);
    e.y  = 10'(v);
    e.de = (h < HA) && (v < VA);
    e.g  = e.de ? luma(mem[(v / 2) * 320 + h / 2]) : 8'd0;
    e.hs = !((h >= HA + HF) && (h < HA + HF + HS));
    e.vs = !((v >= VA + VF) && (v < VA + VF + VS));
    return e;
  endfunction

  // Drives n clks with pclk_en high on every div-th clk; checks the read port
  // before each edge and the scoreboard after it.
  task automatic run(input int n, input int div);
    logic en, act, exp_fs;
    logic [16:0] ea;
    for (int i = 0; i < n; i++) begin
      en      = (i % div) == 0;
      pclk_en = en;
      #1;
      act = en && (mh < HA) && (mv < VA);
      n_vec++;
      if (rd_en !== act) begin
        n_err++;
        $display("FAIL rd_en h=%0d v=%0d got=%b want=%b", mh, mv, rd_en, act);
      end
      if (act) begin
        ea = 17'((mv / 2) * 320 + mh / 2);
        n_vec++;
        if (rd_addr !== ea) begin
          n_err++;
          $display("FAIL rd_addr h=%0d v=%0d got=%0d want=%0d", mh, mv, rd_addr, ea);
        end
      end
      @(posedge clk);
      #1;
      cyc++;
      exp_fs = 1'b0;
      if (en) begin
        q.push_back(model(mh, mv));
        mh++;
        if (mh == HT) begin
          mh = 0;
          mv = (mv == VT - 1) ? 0 : mv + 1;
        end
        if (q.size() == 2) begin
          last      = q.pop_front();
          have_last = 1'b1;
          exp_fs    = (last.x == 0) && (last.y == 0);
        end
      end
      if (have_last) begin
        n_vec++;
        if ({x_pixel, y_pixel, disp_enable, gray, h_sync, v_sync} !== last) begin
          n_err++;
          $display("FAIL pixel got x=%0d y=%0d de=%b g=%0d hs=%b vs=%b want x=%0d y=%0d de=%b g=%0d hs=%b vs=%b",
                   x_pixel, y_pixel, disp_enable, gray, h_sync, v_sync,
                   last.x, last.y, last.de, last.g, last.hs, last.vs);
        end
      end
      n_vec++;
      if (frame_start !== exp_fs) begin
        n_err++;
        $display("FAIL frame_start x=%0d y=%0d got=%b want=%b", x_pixel, y_pixel, frame_start, exp_fs);
      end
      if (frame_start === 1'b1) fs_cnt++;
      if (h_sync === 1'b0) hs_low_cnt++;
      if (v_sync === 1'b0) vs_low_cnt++;
      if (prev_hs === 1'b1 && h_sync === 1'b0) begin
        if (last_fall >= 0) hs_period = cyc - last_fall;
        last_fall = cyc;
      end
      prev_hs = h_sync;
    end
  endtask

  task automatic advance_to(input int h, input int v);
    int guard;
    guard = 0;
    while (!(mh == h && mv == v) && guard < 20000) begin
      run(1, 1);
      guard++;
    end
    n_vec++;
    if (guard >= 20000) begin
      n_err++;
      $display("FAIL advance_to h=%0d v=%0d got h=%0d v=%0d", h, v, mh, mv);
    end
  endtask

  task automatic clear_stats();
    fs_cnt     = 0;
    hs_low_cnt = 0;
    vs_low_cnt = 0;
    last_fall  = -1;
    hs_period  = 0;
    prev_hs    = h_sync;
  endtask

  task automatic test_reset();
    rst_n   = 1'b0;
    pclk_en = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_vec++;
    if ({x_pixel, y_pixel, disp_enable, gray, h_sync, v_sync, frame_start, rd_en, rd_addr}
        !== {10'd0, 10'd0, 1'b0, 8'd0, 1'b1, 1'b1, 1'b0, 1'b0, 17'd0}) begin
      n_err++;
      $display("FAIL reset_state got x=%0d y=%0d de=%b g=%0d hs=%b vs=%b fs=%b rd_en=%b addr=%0d",
               x_pixel, y_pixel, disp_enable, gray, h_sync, v_sync, frame_start, rd_en, rd_addr);
    end
    pclk_en   = 1'b0;
    rst_n     = 1'b1;
    mh        = 0;
    mv        = 0;
    have_last = 1'b0;
    q.delete();
  endtask

  task automatic test_address_map();
    int tbl [5][3];
    tbl = '{'{0, 0, 0}, '{639, 0, 319}, '{1, 1, 0}, '{0, 7, 960}, '{639, 7, 1279}};
    for (int k = 0; k < 5; k++) begin
      advance_to(tbl[k][0], tbl[k][1]);
      pclk_en = 1'b1;
      #1;
      n_vec++;
      if (rd_en !== 1'b1 || rd_addr !== 17'(tbl[k][2])) begin
        n_err++;
        $display("FAIL addr_map h=%0d v=%0d got en=%b addr=%0d want en=1 addr=%0d",
                 tbl[k][0], tbl[k][1], rd_en, rd_addr, tbl[k][2]);
      end
    end
  endtask

  task automatic test_gray();
    logic [7:0] want [5];
    want = '{8'd255, 8'd76, 8'd149, 8'd28, 8'd0};
    for (int k = 0; k < 5; k++) begin
      advance_to(2 * k + 3, 0);
      n_vec++;
      if (x_pixel !== 10'(2 * k + 1) || disp_enable !== 1'b1 || gray !== want[k]) begin
        n_err++;
        $display("FAIL gray word=%0d got x=%0d de=%b g=%0d want x=%0d de=1 g=%0d",
                 k, x_pixel, disp_enable, gray, 2 * k + 1, want[k]);
      end
    end
    advance_to(650, 0);
    n_vec++;
    if (disp_enable !== 1'b0 || gray !== 8'd0 || x_pixel !== 10'd648) begin
      n_err++;
      $display("FAIL gray_blank got x=%0d de=%b g=%0d want x=648 de=0 g=0", x_pixel, disp_enable, gray);
    end
  endtask

  task automatic test_full_rate_timing();
    advance_to(0, 0);
    clear_stats();
    run(2 * HT * VT, 1);
    n_vec++;
    if (fs_cnt !== 2) begin
      n_err++;
      $display("FAIL fs_count got=%0d want=2", fs_cnt);
    end
    n_vec++;
    if (hs_period !== HT) begin
      n_err++;
      $display("FAIL h_period got=%0d want=%0d", hs_period, HT);
    end
    n_vec++;
    if (hs_low_cnt !== 2 * VT * HS) begin
      n_err++;
      $display("FAIL hs_low got=%0d want=%0d", hs_low_cnt, 2 * VT * HS);
    end
    n_vec++;
    if (vs_low_cnt !== 2 * VS * HT) begin
      n_err++;
      $display("FAIL vs_low got=%0d want=%0d", vs_low_cnt, 2 * VS * HT);
    end
  endtask

  task automatic test_half_rate();
    advance_to(0, 1);
    clear_stats();
    run(4 * HT, 2);
    n_vec++;
    if (hs_period !== 2 * HT) begin
      n_err++;
      $display("FAIL h_period_half got=%0d want=%0d", hs_period, 2 * HT);
    end
    n_vec++;
    if (hs_low_cnt !== 4 * HS) begin
      n_err++;
      $display("FAIL hs_low_half got=%0d want=%0d", hs_low_cnt, 4 * HS);
    end
  endtask

  task automatic test_reset_mid_frame();
    advance_to(300, 5);
    #2;
    rst_n   = 1'b0;
    pclk_en = 1'b1;
    #1;
    n_vec++;
    if ({x_pixel, y_pixel, disp_enable, gray, h_sync, v_sync, frame_start, rd_en, rd_addr}
        !== {10'd0, 10'd0, 1'b0, 8'd0, 1'b1, 1'b1, 1'b0, 1'b0, 17'd0}) begin
      n_err++;
      $display("FAIL reset_async got x=%0d y=%0d de=%b g=%0d hs=%b vs=%b fs=%b rd_en=%b addr=%0d",
               x_pixel, y_pixel, disp_enable, gray, h_sync, v_sync, frame_start, rd_en, rd_addr);
    end
    repeat (2) @(posedge clk);
    #1;
    rst_n     = 1'b1;
    mh        = 0;
    mv        = 0;
    have_last = 1'b0;
    q.delete();
    clear_stats();
    run(1500, 1);
    n_vec++;
    if (fs_cnt !== 1) begin
      n_err++;
      $display("FAIL restart_fs got=%0d want=1", fs_cnt);
    end
  endtask

  initial begin
    n_vec     = 0;
    n_err     = 0;
    cyc       = 0;
    have_last = 1'b0;
    for (int i = 0; i < 76800; i++) mem[i] = 16'($urandom);
    mem[0] = 16'hFFFF;
    mem[1] = 16'hF800;
    mem[2] = 16'h07E0;
    mem[3] = 16'h001F;
    mem[4] = 16'h0000;
    clear_stats();
    test_reset();
    test_address_map();
    test_gray();
    test_full_rate_timing();
    test_half_rate();
    test_reset_mid_frame();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
